// File: rtl/aes_key_pkg.sv
// Shared AES key-schedule types and constants.
// Used by the reverse AES-128 key schedule generator.
package aes_key_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned KEY_W  = 128;

  typedef logic [WORD_W-1:0] aes_word_t;
  typedef logic [KEY_W-1:0]  aes_key128_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } key_unexp_state_e;

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Rcon lookup by round index; indices outside 1..10 return zero.
  function automatic logic [7:0] rcon_of(input logic [3:0] r);
    logic [7:0] v;
    v = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (r == 4'(i)) v = RCON[i];
    end
    return v;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Forward AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p;
    logic [7:0] xx;
    p  = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 == x^-1 for nonzero x, and maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  logic [7:0] b;

  always_comb begin
    b = gf_inv(a);
    s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_unexpand_128.sv
// Reverse AES-128 key schedule: loads round key 10 and emits round keys 10..0
// one per accepted valid/ready beat, for the inverse cipher.
module aes_key_unexpand_128
  import aes_key_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key_last,
  output logic [127:0] key_out,
  output logic [3:0]   key_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy,
  output logic         done
);

  key_unexp_state_e state_q, state_d;
  aes_key128_t      key_q, key_d;
  logic [3:0]       round_q, round_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  aes_word_t w4, w5, w6, w7;
  aes_word_t p0, p1, p2, p3;
  aes_word_t rot_w, sub_w;
  aes_key128_t prev_key;
  logic accept;

  // Reverse step: round r key (w4..w7) -> round r-1 key (p0..p3).
  assign w4 = key_q[127:96];
  assign w5 = key_q[95:64];
  assign w6 = key_q[63:32];
  assign w7 = key_q[31:0];

  assign p3    = w7 ^ w6;
  assign p2    = w6 ^ w5;
  assign p1    = w5 ^ w4;
  assign rot_w = {p3[23:0], p3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a(rot_w[8*g +: 8]),
      .s(sub_w[8*g +: 8])
    );
  end

  assign p0       = w4 ^ sub_w ^ {rcon_of(round_q), 24'h000000};
  assign prev_key = {p0, p1, p2, p3};
  assign accept   = valid_q & out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      round_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Load has priority over any beat accept, including the final one.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (ld) begin
      state_d = ST_EMIT;
      key_d   = key_last;
      round_d = 4'(NR);
      valid_d = 1'b1;
      busy_d  = 1'b1;
    end else if (state_q == ST_EMIT && accept) begin
      if (round_q != 4'd0) begin
        key_d   = prev_key;
        round_d = round_q - 4'd1;
      end else begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
    end
  end

  assign key_out   = key_q;
  assign key_round = round_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_aes_key_unexpand_128.sv
// Scoreboard bench for the reverse AES-128 key schedule generator.
module tb_aes_key_unexpand_128;

  typedef struct {
    logic [3:0]   round;
    logic [127:0] key;
  } beat_t;

  localparam logic [127:0] K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [7:0] TB_RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  logic         clk = 1'b0;
  logic         rst, ld, out_ready;
  logic [127:0] key_last, key_out;
  logic [3:0]   key_round;
  logic         out_valid, busy, done;

  int    tests = 0;
  int    fails = 0;
  bit    mon_en = 1'b0;
  bit    exp_done = 1'b0;
  beat_t exp_q[$];
  logic [127:0] ref_rk [0:10];
  logic [7:0]   sbox_t [0:255];

  always #5 clk = ~clk;

  aes_key_unexpand_128 dut (
    .clk(clk), .rst(rst), .ld(ld), .key_last(key_last),
    .key_out(key_out), .key_round(key_round), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, xx;
    p = 8'h00;
    xx = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box table: inverse found by exhaustive search, affine map bit by bit.
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      end
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    logic [31:0] r;
    r = {w[23:0], w[31:24]};
    return {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
  endfunction

  task automatic fwd_expand(input logic [127:0] k0);
    logic [31:0] w [0:43];
    logic [31:0] t;
    w[0] = k0[127:96]; w[1] = k0[95:64]; w[2] = k0[63:32]; w[3] = k0[31:0];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_rot(t) ^ {TB_RCON[i/4], 24'h000000};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic rev_walk(input logic [127:0] k10);
    logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;
    ref_rk[10] = k10;
    for (int r = 10; r >= 1; r--) begin
      {w4, w5, w6, w7} = ref_rk[r];
      w3 = w7 ^ w6;
      w2 = w6 ^ w5;
      w1 = w5 ^ w4;
      w0 = w4 ^ sub_rot(w3) ^ {TB_RCON[r], 24'h000000};
      ref_rk[r-1] = {w0, w1, w2, w3};
    end
  endtask

  // Issue a load and replace any outstanding expectations with the new sequence.
  task automatic load(input logic [127:0] k);
    key_last = k;
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
    exp_q.delete();
    for (int r = 10; r >= 0; r--) exp_q.push_back('{round: 4'(r), key: ref_rk[r]});
  endtask

  task automatic wait_round(input int r);
    int n = 0;
    while (!(out_valid && key_round == 4'(r)) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n >= 100) begin
      fails++;
      $display("FAIL wait_round%0d: timed out, key_round=%0d expected %0d", r, key_round, r);
    end
  endtask

  task automatic drain(input bit bp);
    int n = 0;
    while (exp_q.size() > 0 && n < 300) begin
      if (bp) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n >= 300) begin
      fails++;
      $display("FAIL drain: timed out with %0d beats outstanding, expected 0", exp_q.size());
    end
    out_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // Monitor: compare presented beat against the scoreboard head every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("done", 128'(done), 128'(exp_done));
      exp_done = 1'b0;
      check("out_valid", 128'(out_valid), 128'(exp_q.size() > 0));
      check("busy", 128'(busy), 128'(exp_q.size() > 0));
      if (out_valid && exp_q.size() > 0) begin
        check("key_round", 128'(key_round), 128'(exp_q[0].round));
        check("key_out", key_out, exp_q[0].key);
        if (out_ready) begin
          if (exp_q[0].round == 4'd0 && !ld && rst) exp_done = 1'b1;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; ld = 1'b0; out_ready = 1'b0; key_last = '0;
    build_sbox();
    repeat (2) @(posedge clk);
    #1;
    check("rst_key_out", key_out, 128'h0);
    check("rst_key_round", 128'(key_round), 128'h0);
    check("rst_out_valid", 128'(out_valid), 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_done", 128'(done), 128'h0);
    rst = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 A.1 with hand-known rounds 10, 9 and 0
    out_ready = 1'b1;
    fwd_expand(K0);
    ref_rk[10] = K10; ref_rk[9] = K9; ref_rk[0] = K0;
    load(K10);
    drain(1'b0);

    // Random backpressure
    out_ready = 1'b0;
    fwd_expand(K0);
    load(K10);
    drain(1'b1);

    // Reload while round 5 is presented
    fwd_expand(K0);
    load(K10);
    wait_round(5);
    rev_walk(128'h00112233445566778899aabbccddeeff);
    load(128'h00112233445566778899aabbccddeeff);
    drain(1'b0);

    // Load coincident with the final accept
    fwd_expand(K0);
    load(K10);
    wait_round(0);
    rev_walk(128'hffffffffffffffffffffffffffffffff);
    load(128'hffffffffffffffffffffffffffffffff);
    drain(1'b0);

    // Reset in the middle of a sequence
    fwd_expand(K0);
    load(K10);
    wait_round(7);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    check("mid_rst_key_out", key_out, 128'h0);
    check("mid_rst_key_round", 128'(key_round), 128'h0);
    check("mid_rst_out_valid", 128'(out_valid), 128'h0);
    check("mid_rst_busy", 128'(busy), 128'h0);
    check("mid_rst_done", 128'(done), 128'h0);
    fwd_expand(K0);
    load(K10);
    drain(1'b0);

    // All-zero final key exercises Rcon 1b/36
    rev_walk(128'h0);
    load(128'h0);
    drain(1'b0);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_key_unexpand_128.md
# aes_key_unexpand_128

Reverse AES-128 key schedule generator for the decryption path. It is the inverse-direction counterpart of the forward key expander in `aes_cipher_top`. It loads the final (round-10) round key and walks the schedule backwards, one round per accepted beat. It emits round keys 10, 9, …, 0 under a valid/ready handshake, which is the order the inverse cipher consumes them. It sits between the key store and the inverse cipher datapath.

## Interface
Parameters:
- `NR`, default 10, number of rounds; fixed to 10 for AES-128 and not user-overridable in practice.

Ports:
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst`, input, 1, synchronous reset, active-low.
- `ld`, input, 1, one-cycle load strobe; samples `key_last`.
- `key_last`, input, 128, round-10 key; word 0 is in [127:96].
- `key_out`, output, 128, current round key, same word order as `key_last`.
- `key_round`, output, 4, round index of `key_out`, 10 down to 0.
- `out_valid`, output, 1, `key_out`/`key_round` are valid.
- `out_ready`, input, 1, consumer accepts the beat when `out_valid & out_ready`.
- `busy`, output, 1, a sequence is in progress.
- `done`, output, 1, one-cycle pulse after round 0 is accepted.

## Operation
- States: IDLE, EMIT.
- IDLE:
  - outputs `out_valid=0`, `busy=0`.
  - `ld=1` → register `key_last` into the `w0..w3` state, set round counter to 10, go to EMIT.
- EMIT:
  - `out_valid=1`, `busy=1`, `key_out` = state words, `key_round` = counter.
  - Beat accepted and counter ≠ 0 → state becomes the previous round key, counter decrements.
  - Beat accepted and counter = 0 → go to IDLE and pulse `done`.
  - No accept → state, counter and outputs hold, stable until accepted.
- Reverse step, from round r key (w4..w7) to round r−1 key (w0..w3):
  - w3 = w7^w6
  - w2 = w6^w5
  - w1 = w5^w4
  - w0 = w4 ^ SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}
- RotWord rotates left by one byte. SubWord is four forward S-boxes, not inverse.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Index r is the round being undone.
- `ld` has priority over everything, including in EMIT and during a stalled beat:
  - reload and restart at round 10.
  - the in-flight sequence is abandoned and no `done` is issued for it.
- `ld` in the same cycle as the final accept → reload wins; `done` is not pulsed.
- Reset (`rst=0` at an edge), from any state:
  - state goes to IDLE.
  - `key_out=0`, `key_round=0`, `out_valid=0`, `busy=0`, `done=0`.

## Timing
- `ld` sampled at edge t → `out_valid=1` with `key_round=10` and `key_out=key_last` from t+1.
- One reverse round per accepted beat. With `out_ready` held high, all 11 keys appear on 11 consecutive cycles, t+1 … t+11.
- `done` is high for exactly the cycle after the round-0 accept. `out_valid` is 0 in that same cycle.
- The reverse step is a single combinational stage (4 S-boxes + XORs) feeding the state register. There is no added pipeline latency.
- `out_valid` never drops while a beat is unaccepted, except through `ld` or reset.

## Structure
- Shared package `aes_key_pkg`:
  - `aes_word_t` (32-bit) typedef.
  - `aes_key128_t` typedef.
  - `RCON` constant array [1:10].
  - state enum `key_unexp_state_e`.
- Sub-module: reuse the existing `aes_sbox` (byte in, byte out, combinational), instantiated 4×.
- Top contains:
  - the FSM.
  - a 4-bit round counter.
  - a 128-bit state register.
  - the reverse-step XOR network.

## Test plan
- FIPS-197 A.1:
  - stimulus: `ld` with `key_last`=d014f9a8 c9ee2589 e13f0cc8 b6630ca6, `out_ready`=1.
  - beats 10 and 9: round 10 = that key; round 9 = ac7766f3 19fadc21 28d12941 575c006e.
  - beat 0: round 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c.
  - end: `done` pulses one cycle after beat 0.
- Backpressure:
  - stimulus: same key, `out_ready` toggling randomly.
  - required: `key_out`/`key_round` hold while stalled; the 11-key sequence matches a forward-expansion reference model.
- Mid-sequence reload: `ld` with a new key while `key_round`=5 → next cycle shows `key_round`=10 with the new key; no `done` for the first sequence.
- Simultaneous final accept and `ld` → no `done`; new sequence starts at round 10.
- Reset mid-EMIT:
  - stimulus: `rst`=0 for one edge.
  - required: all outputs 0 the next cycle; `ld` after reset works normally.
- All-zero key_last, 11 beats → every round key matches the reference model; checks the Rcon 1b/36 wrap entries.
